// File: rtl/addslice_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : addslice_rr_sequencer
// Brief    : Round-robin sharing of one external 4-bit adder slice between two
//            requesters; wide add performed one nibble per cycle, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module addslice_rr_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id,
    output logic                   busy
);

    localparam int c_WIDTH = 4 * NIBBLES;
    localparam int c_IDX_W = $clog2(NIBBLES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic                r_rr;
    logic [c_WIDTH-1:0]  r_a;
    logic [c_WIDTH-1:0]  r_b;
    logic [c_WIDTH-1:0]  r_sum;
    logic                r_carry;
    logic                r_cout;
    logic                r_id;
    logic                r_res_valid;
    logic                r_busy;
    logic [c_IDX_W-1:0]  r_idx;

    logic w_idle;
    logic w_run;
    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;

    // Reset gates ready so no handshake can be advertised while held in reset.
    assign w_idle   = (r_state == c_IDLE) && rst_n;
    assign w_run    = (r_state == c_RUN);
    assign w_grant0 = req0_valid && (!req1_valid || !r_rr);
    assign w_grant1 = req1_valid && (!req0_valid ||  r_rr);

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;

    // Operand registers shift right each RUN cycle, so the live nibble is always [3:0].
    assign add_a   = w_run ? r_a[3:0] : 4'h0;
    assign add_b   = w_run ? r_b[3:0] : 4'h0;
    assign add_cin = w_run ? r_carry  : 1'b0;

    assign res_valid = r_res_valid;
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_id    = r_id;
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_id        <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_a     <= w_acc1 ? req1_a : req0_a;
                        r_b     <= w_acc1 ? req1_b : req0_b;
                        r_id    <= w_acc1;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    // Sum nibbles enter at the top; after NIBBLES steps nibble 0 sits at [3:0].
                    r_sum   <= {add_sum, r_sum[c_WIDTH-1:4]};
                    r_carry <= add_cout;
                    if (r_idx == c_LAST_IDX) begin
                        r_cout      <= add_cout;
                        r_res_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rr        <= !r_id;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addslice_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addslice_rr_sequencer
// Brief    : Scoreboard bench for addslice_rr_sequencer with an external
//            4-bit adder slice model and a cycle model of arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addslice_rr_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0] res_sum;

    always #5 clk = ~clk;

    // External 4-bit slice: purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    addslice_rr_sequencer #(.NIBBLES(NIBBLES)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_accepts = 0;
    int   n_results = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    logic [1:0]   m_state = M_IDLE;
    logic         m_rr = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int           m_idx = 0;
    int           m_lat = 0;
    logic         m_first = 1'b0;
    exp_t         m_last = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor + model: samples on the falling edge, inputs are those seen at the next rising edge.
    always @(negedge clk) begin
        logic        e_r0, e_r1;
        logic [63:0] a64, b64, mask, nib_a, nib_b, cin_e;
        exp_t        e;
        cyc++;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_rr    = 1'b0;
            m_idx   = 0;
            m_lat   = 0;
            m_first = 1'b0;
            m_last  = '0;
            exp_q.delete();
        end else begin
            if (m_state != M_IDLE) m_lat++;
            e_r0 = (m_state == M_IDLE) && req0_valid && (!req1_valid || !m_rr);
            e_r1 = (m_state == M_IDLE) && req1_valid && (!req0_valid ||  m_rr);
            check_eq("req0_ready", 64'(req0_ready), 64'(e_r0));
            check_eq("req1_ready", 64'(req1_ready), 64'(e_r1));
            check_eq("busy", 64'(busy), 64'(m_state != M_IDLE));
            check_eq("res_valid", 64'(res_valid), 64'(m_state == M_DONE));

            if (m_state == M_RUN) begin
                a64   = 64'(m_a);
                b64   = 64'(m_b);
                mask  = (64'd1 << (4 * m_idx)) - 64'd1;
                nib_a = (a64 >> (4 * m_idx)) & 64'hF;
                nib_b = (b64 >> (4 * m_idx)) & 64'hF;
                cin_e = ((a64 & mask) + (b64 & mask)) >> (4 * m_idx);
                check_eq("add_a", 64'(add_a), nib_a);
                check_eq("add_b", 64'(add_b), nib_b);
                check_eq("add_cin", 64'(add_cin), cin_e);
            end else begin
                check_eq("add_idle", 64'({add_a, add_b, add_cin}), 64'd0);
            end

            if (m_state == M_DONE) begin
                if (m_first) begin
                    check_eq("latency", 64'(m_lat), 64'(NIBBLES + 1));
                    m_first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check_eq("sb_empty", 64'd0, 64'd1);
                end else begin
                    check_eq("res_sum", 64'(res_sum), 64'(exp_q[0].sum));
                    check_eq("res_cout", 64'(res_cout), 64'(exp_q[0].cout));
                    check_eq("res_id", 64'(res_id), 64'(exp_q[0].id));
                end
            end else if (m_state == M_IDLE) begin
                check_eq("hold_result", 64'({res_id, res_cout, res_sum}),
                         64'({m_last.id, m_last.cout, m_last.sum}));
            end

            case (m_state)
                M_IDLE: begin
                    if (e_r0 || e_r1) begin
                        m_a = e_r1 ? req1_a : req0_a;
                        m_b = e_r1 ? req1_b : req0_b;
                        e.id = e_r1;
                        {e.cout, e.sum} = {1'b0, m_a} + {1'b0, m_b};
                        exp_q.push_back(e);
                        m_state = M_RUN;
                        m_idx   = 0;
                        m_lat   = 0;
                        n_accepts++;
                        acc_cyc = cyc;
                    end
                end
                M_RUN: begin
                    if (m_idx == NIBBLES - 1) begin
                        m_state = M_DONE;
                        m_first = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
                default: begin
                    if (res_ready && exp_q.size() != 0) begin
                        m_last  = exp_q.pop_front();
                        m_rr    = !m_last.id;
                        m_state = M_IDLE;
                        n_results++;
                    end
                end
            endcase
        end
    end

    task automatic wait_accepts(input int target);
        int t = 0;
        while (n_accepts < target && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_accepts < target) check_eq("accept_timeout", 64'(n_accepts), 64'(target));
    endtask

    task automatic wait_results(input int target);
        int t = 0;
        while (n_results < target && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_results < target) check_eq("result_timeout", 64'(n_results), 64'(target));
    endtask

    task automatic wait_res_valid();
        int t = 0;
        while (!res_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("res_valid_seen", 64'(res_valid), 64'd1);
    endtask

    initial begin
        int base_a, base_r, prev;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 64'({res_valid, busy, req0_ready, req1_ready, add_a, add_b, add_cin}), 64'd0);
        check_eq("rst_res", 64'({res_id, res_cout, res_sum}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single req0 job
        req0_a = 16'h1234; req0_b = 16'h4321; req0_valid = 1'b1;
        wait_accepts(1);
        req0_valid = 1'b0;
        wait_results(1);

        // Single req1 job with full carry ripple
        req1_a = 16'hFFFF; req1_b = 16'h0001; req1_valid = 1'b1;
        wait_accepts(2);
        req1_valid = 1'b0;
        wait_results(2);

        // Both valid from reset: grants must alternate
        rst_n = 1'b0;
        req0_a = 16'h00FF; req0_b = 16'h0F01; req1_a = 16'h00FF; req1_b = 16'h0F01;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_a = n_accepts; base_r = n_results;
        wait_accepts(base_a + 3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_results(base_r + 3);

        // Backpressure in DONE; a short req0 pulse and a held req1 must not be taken
        res_ready = 1'b0;
        req0_a = 16'hABCD; req0_b = 16'h1357; req0_valid = 1'b1;
        base_a = n_accepts; base_r = n_results;
        wait_accepts(base_a + 1);
        req0_valid = 1'b0;
        req1_a = 16'h7777; req1_b = 16'h9999; req1_valid = 1'b1;
        wait_res_valid();
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_hold_valid", 64'(res_valid), 64'd1);
        check_eq("bp_no_accept", 64'(n_accepts), 64'(base_a + 1));
        res_ready = 1'b1;
        wait_results(base_r + 1);
        wait_accepts(base_a + 2);
        req1_valid = 1'b0;
        wait_results(base_r + 2);

        // Reset during the second RUN cycle aborts the job
        req0_a = 16'h1111; req0_b = 16'h2222; req0_valid = 1'b1;
        base_a = n_accepts;
        wait_accepts(base_a + 1);
        req0_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_ctrl", 64'({res_valid, busy, req0_ready, req1_ready, add_a, add_b, add_cin}), 64'd0);
        check_eq("abort_res", 64'({res_id, res_cout, res_sum}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base_a = n_accepts; base_r = n_results;
        req0_a = 16'h8000; req0_b = 16'h8000; req0_valid = 1'b1;
        wait_accepts(base_a + 1);
        req0_valid = 1'b0;
        wait_results(base_r + 1);

        // req0 streaming with valid held high
        base_a = n_accepts; base_r = n_results; prev = 0;
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_accepts(base_a + k);
            if (k > 1) check_eq("stream_period", 64'(acc_cyc - prev), 64'(NIBBLES + 2));
            prev = acc_cyc;
            req0_a = 16'($urandom); req0_b = 16'($urandom);
        end
        req0_valid = 1'b0;
        wait_results(base_r + 4);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
